common_dffram_wrctrl: RTL and testbench
=======================================

Name: common_dffram_wrctrl

Overview:
Write-port controller for the team's DFF RAM (simple dual-port: one write port, one read port, write enable).
- Shares the single RAM write port between two requesters using round-robin arbitration.
- Runs a clear sequencer that writes a fill value to every RAM entry after reset and on request.
- Sits between producer logic and the RAM write port. The RAM read port is not touched by this block.

Parameters:
RAM_DATA_WIDTH, 1, width of the RAM word
RAM_ADDR_WIDTH, 1, RAM address width; DEPTH = 1 << RAM_ADDR_WIDTH
CLEAR_VALUE, 0 (RAM_DATA_WIDTH bits), word written to every entry during a clear sweep

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high reset
clear_req  in  1  one-cycle pulse requesting a full-RAM clear
clear_busy  out  1  high while the clear sweep is running
req0_valid  in  1  requester 0 has a write pending
req0_addr  in  RAM_ADDR_WIDTH  requester 0 write address
req0_data  in  RAM_DATA_WIDTH  requester 0 write data
req0_ready  out  1  requester 0 write accepted this cycle
req1_valid  in  1  requester 1 has a write pending
req1_addr  in  RAM_ADDR_WIDTH  requester 1 write address
req1_data  in  RAM_DATA_WIDTH  requester 1 write data
req1_ready  out  1  requester 1 write accepted this cycle
ram_addra  out  RAM_ADDR_WIDTH  RAM write address
ram_ena  out  1  RAM port enable
ram_wea  out  1  RAM write enable
ram_dina  out  RAM_DATA_WIDTH  RAM write data

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- States: CLEAR and RUN. Reset forces CLEAR with sweep counter = 0 and priority pointer = requester 0.
- Reset values:
  - ram_ena = 0, ram_wea = 0, ram_addra = 0, ram_dina = 0.
  - clear_busy = 1 (state is CLEAR).
  - req0_ready = 0, req1_ready = 0.
- RAM port outputs are registered: each write reaches the RAM port one cycle after its decision. ram_ena and ram_wea are always equal.
- CLEAR state, at each edge:
  - Register ram_addra <= counter, ram_dina <= CLEAR_VALUE, ram_ena = ram_wea <= 1.
  - Increment the counter.
  - When counter == DEPTH-1, go to RUN. The counter wraps to 0.
  - clear_busy stays high for exactly DEPTH cycles after entry.
  - Both readies are held at 0.
  - clear_req is ignored.
- RUN state:
  - reqN_ready is combinational: reqN_valid & grantN & !clear_req.
  - A transfer happens when valid & ready are both high.
  - Only one requester valid: it is granted, whatever the pointer says.
  - Both requesters valid: the pointer's requester is granted.
  - After any transfer, the pointer moves to the other requester.
  - A transfer registers the winner's addr and data onto the RAM port with ram_ena = ram_wea = 1 at the next edge. Otherwise ram_ena = ram_wea <= 0, and ram_addra/ram_dina hold their values.
- clear_req in RUN:
  - That cycle, no transfer is accepted (both readies 0).
  - The next state is CLEAR with counter 0.
  - Any write already registered on the port still completes, so a clear always follows earlier writes.
- Ordering at CLEAR to RUN:
  - The last clear write (address DEPTH-1) appears on the port in the first RUN cycle.
  - A write accepted in that cycle reaches the port one cycle later, so no collision occurs.
- Requester expectations: requesters hold valid/addr/data stable until ready is seen. The block does not check this.
- Reset mid-sweep or mid-write:
  - Drops all pending activity and restarts the sweep at address 0.
  - Drives the port outputs to their reset values in the reset cycle.
  - Sets the pointer back to requester 0.
- No address-width arithmetic beyond the counter. Counter width is RAM_ADDR_WIDTH.

Test Plan:
1. RAM_ADDR_WIDTH=2, RAM_DATA_WIDTH=8, CLEAR_VALUE=8'hA5; release reset with both requesters valid -> clear_busy high 4 cycles; RAM port writes addresses 0,1,2,3 with data A5 on consecutive cycles; readies stay 0 until clear_busy falls.
2. RUN, only req1_valid with addr=2, data=8'h3C -> req1_ready=1 the same cycle; next cycle ram_ena=ram_wea=1, ram_addra=2, ram_dina=3C; the following cycle ram_ena=0.
3. RUN, both valid continuously, req0 data 11/12/13 and req1 data 21/22/23 -> grants go 0,1,0,1,0,1; RAM port data goes 11,21,12,22,13,23 with no idle cycle.
4. RUN, both valid, clear_req pulse -> both readies 0 that cycle; 4-cycle sweep writes A5 to addresses 0..3; a second clear_req during the sweep does not extend it; requests are served afterwards.
5. Reset asserted at sweep counter 2 -> next cycle ram_ena=0 and all outputs at reset values; after release the sweep restarts at address 0 and runs all 4 writes.
6. Back-to-back edge case: a req0 write accepted in the first RUN cycle after a sweep -> the port shows address 3 (clear write), then the req0 write in the next cycle.

Source files
------------

// File: rtl/common_dffram_wrctrl.sv
// Write-port controller for the DFF RAM: round-robin sharing of the single
// write port between two requesters, plus a clear sweep that fills every
// entry with CLEAR_VALUE after reset and on request.
module common_dffram_wrctrl #(
  parameter int unsigned                RAM_DATA_WIDTH = 1,
  parameter int unsigned                RAM_ADDR_WIDTH = 1,
  parameter logic [RAM_DATA_WIDTH-1:0]  CLEAR_VALUE    = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_req,
  output logic                      clear_busy,
  input  logic                      req0_valid,
  input  logic [RAM_ADDR_WIDTH-1:0] req0_addr,
  input  logic [RAM_DATA_WIDTH-1:0] req0_data,
  output logic                      req0_ready,
  input  logic                      req1_valid,
  input  logic [RAM_ADDR_WIDTH-1:0] req1_addr,
  input  logic [RAM_DATA_WIDTH-1:0] req1_data,
  output logic                      req1_ready,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addra,
  output logic                      ram_ena,
  output logic                      ram_wea,
  output logic [RAM_DATA_WIDTH-1:0] ram_dina
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  // All-ones address is the last entry (DEPTH-1).
  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                      r_state;
  logic [RAM_ADDR_WIDTH-1:0]   r_cnt;
  logic                        r_ptr;      // 0: requester 0 has priority
  logic                        r_ram_en;
  logic [RAM_ADDR_WIDTH-1:0]   r_ram_addr;
  logic [RAM_DATA_WIDTH-1:0]   r_ram_din;

  state_t                      w_state_nxt;
  logic [RAM_ADDR_WIDTH-1:0]   w_cnt_nxt;
  logic                        w_ptr_nxt;
  logic                        w_en_nxt;
  logic [RAM_ADDR_WIDTH-1:0]   w_addr_nxt;
  logic [RAM_DATA_WIDTH-1:0]   w_din_nxt;
  logic                        w_grant0;
  logic                        w_grant1;
  logic                        w_rdy0;
  logic                        w_rdy1;

  // A lone requester always wins; with both valid the pointer decides.
  assign w_grant0 = !req1_valid || !r_ptr;
  assign w_grant1 = !req0_valid ||  r_ptr;

  assign clear_busy = (r_state == S_CLEAR);
  assign req0_ready = w_rdy0;
  assign req1_ready = w_rdy1;
  assign ram_addra  = r_ram_addr;
  assign ram_ena    = r_ram_en;
  assign ram_wea    = r_ram_en;
  assign ram_dina   = r_ram_din;

  // Next-state, arbitration and next RAM-port values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_en_nxt    = 1'b0;
    w_addr_nxt  = r_ram_addr;
    w_din_nxt   = r_ram_din;
    w_rdy0      = 1'b0;
    w_rdy1      = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_en_nxt   = 1'b1;
        w_addr_nxt = r_cnt;
        w_din_nxt  = CLEAR_VALUE;
        w_cnt_nxt  = r_cnt + RAM_ADDR_WIDTH'(1);
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (clear_req) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end else begin
          w_rdy0 = req0_valid && w_grant0;
          w_rdy1 = req1_valid && w_grant1;
          if (w_rdy0) begin
            w_en_nxt   = 1'b1;
            w_addr_nxt = req0_addr;
            w_din_nxt  = req0_data;
            w_ptr_nxt  = 1'b1;
          end else if (w_rdy1) begin
            w_en_nxt   = 1'b1;
            w_addr_nxt = req1_addr;
            w_din_nxt  = req1_data;
            w_ptr_nxt  = 1'b0;
          end
        end
      end
    endcase
  end

  // Control state: FSM state, sweep counter and priority pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_ptr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Registered RAM write port; address/data hold when no write is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_en   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
    end else begin
      r_ram_en   <= w_en_nxt;
      r_ram_addr <= w_addr_nxt;
      r_ram_din  <= w_din_nxt;
    end
  end

endmodule

// File: tb/tb_common_dffram_wrctrl.sv
// Bench for common_dffram_wrctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the write port.
module tb_common_dffram_wrctrl;

  localparam int        AW    = 2;
  localparam int        DW    = 8;
  localparam int        DEPTH = 4;
  localparam logic [7:0] CV   = 8'hA5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear_req = 1'b0;
  logic          clear_busy;
  logic          req0_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_data = '0;
  logic          req1_ready;
  logic [AW-1:0] ram_addra;
  logic          ram_ena;
  logic          ram_wea;
  logic [DW-1:0] ram_dina;

  always #5 clk = ~clk;

  common_dffram_wrctrl #(
    .RAM_DATA_WIDTH (DW),
    .RAM_ADDR_WIDTH (AW),
    .CLEAR_VALUE    (CV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .ram_addra  (ram_addra),
    .ram_ena    (ram_ena),
    .ram_wea    (ram_wea),
    .ram_dina   (ram_dina)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: clear writes still owed, next clear address, who is
  // favoured on a tie, and what the RAM port is expected to show.
  bit m_known = 0;
  int m_left  = 0;
  int m_caddr = 0;
  bit m_prio  = 0;
  bit m_en    = 0;
  int m_addr  = 0;
  int m_din   = 0;
  bit m_r0, m_r1;

  // Requester-side pending writes (held until accepted).
  bit p0v = 0, p1v = 0;
  int p0a = 0, p0d = 0, p1a = 0, p1d = 0;

  bit log_on = 0;
  int port_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check #1 later, advance model, wait posedge.
  task automatic cycle(input bit rst, input bit clr);
    @(negedge clk);
    reset      = rst;
    clear_req  = clr;
    req0_valid = p0v;
    req0_addr  = AW'(p0a);
    req0_data  = DW'(p0d);
    req1_valid = p1v;
    req1_addr  = AW'(p1a);
    req1_data  = DW'(p1d);
    #1;
    m_r0 = 0;
    m_r1 = 0;
    if (m_left == 0 && !clr) begin
      if (p0v && (!p1v || !m_prio)) m_r0 = 1;
      else if (p1v)                 m_r1 = 1;
    end
    if (m_known) begin
      chk("ram_ena",    32'(ram_ena),    32'(m_en));
      chk("ram_wea",    32'(ram_wea),    32'(m_en));
      chk("ram_addra",  32'(ram_addra),  32'(m_addr));
      chk("ram_dina",   32'(ram_dina),   32'(m_din));
      chk("clear_busy", 32'(clear_busy), 32'(m_left > 0));
      chk("req0_ready", 32'(req0_ready), 32'(m_r0));
      chk("req1_ready", 32'(req1_ready), 32'(m_r1));
      if (log_on && ram_ena === 1'b1) port_log.push_back(int'(ram_dina));
    end
    if (rst) begin
      m_known = 1;
      m_left  = DEPTH;
      m_caddr = 0;
      m_prio  = 0;
      m_en    = 0;
      m_addr  = 0;
      m_din   = 0;
    end else if (m_left > 0) begin
      m_en    = 1;
      m_addr  = m_caddr;
      m_din   = int'(CV);
      m_caddr = (m_caddr + 1) % DEPTH;
      m_left  = m_left - 1;
    end else if (clr) begin
      m_left  = DEPTH;
      m_caddr = 0;
      m_en    = 0;
    end else if (m_r0) begin
      m_en = 1; m_addr = p0a; m_din = p0d; m_prio = 1;
    end else if (m_r1) begin
      m_en = 1; m_addr = p1a; m_din = p1d; m_prio = 0;
    end else begin
      m_en = 0;
    end
    if (m_r0) p0v = 0;
    if (m_r1) p1v = 0;
    @(posedge clk);
  endtask

  initial begin
    int q0[$];
    int q1[$];
    int exp_seq[$];
    int n;

    // 1: reset, then release with both requesters waiting through the sweep
    cycle(1, 0);
    cycle(1, 0);
    p0v = 1; p0a = 1; p0d = 8'h5A;
    p1v = 1; p1a = 3; p1d = 8'h77;
    for (int i = 0; i < 7; i++) cycle(0, 0);
    n = 0;
    while ((p0v || p1v) && n < 20) begin cycle(0, 0); n++; end
    chk("drain_initial", 32'(p0v || p1v), 32'd0);
    cycle(0, 0);

    // 2: lone req1 write
    p1v = 1; p1a = 2; p1d = 8'h3C;
    cycle(0, 0);
    #1;
    chk("t2_ena",  32'(ram_ena),   32'd1);
    chk("t2_addr", 32'(ram_addra), 32'd2);
    chk("t2_data", 32'(ram_dina),  32'h3C);
    cycle(0, 0);
    cycle(0, 0);

    // 3: both valid continuously, alternating grants, no idle port cycle
    q0 = '{8'h11, 8'h12, 8'h13};
    q1 = '{8'h21, 8'h22, 8'h23};
    log_on = 1;
    port_log.delete();
    for (int i = 0; i < 8; i++) begin
      if (!p0v && q0.size() > 0) begin p0v = 1; p0a = 0; p0d = q0.pop_front(); end
      if (!p1v && q1.size() > 0) begin p1v = 1; p1a = 1; p1d = q1.pop_front(); end
      cycle(0, 0);
    end
    log_on = 0;
    exp_seq = '{8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
    chk("t3_count", 32'(port_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < port_log.size(); i++)
      chk("t3_seq", 32'(port_log[i]), 32'(exp_seq[i]));

    // 4: clear request with both valid; second request mid-sweep ignored
    p0v = 1; p0a = 3; p0d = 8'h44;
    p1v = 1; p1a = 0; p1d = 8'h55;
    cycle(0, 1);
    cycle(0, 0);
    cycle(0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0);
    chk("t4_served", 32'(p0v || p1v), 32'd0);

    // 5: reset when the sweep counter reaches 2
    cycle(0, 1);
    cycle(0, 0);
    cycle(0, 0);
    cycle(1, 0);
    #1;
    chk("t5_ena",  32'(ram_ena),    32'd0);
    chk("t5_addr", 32'(ram_addra),  32'd0);
    chk("t5_busy", 32'(clear_busy), 32'd1);

    // 6: req0 accepted in first RUN cycle after the restarted sweep
    p0v = 1; p0a = 1; p0d = 8'hE7;
    for (int i = 0; i < 7; i++) cycle(0, 0);

    // Random traffic with occasional clear and reset
    for (int i = 0; i < 400; i++) begin
      if (!p0v && $urandom_range(0, 3) != 0) begin
        p0v = 1; p0a = int'($urandom_range(0, DEPTH - 1)); p0d = int'($urandom_range(0, 255));
      end
      if (!p1v && $urandom_range(0, 3) != 0) begin
        p1v = 1; p1a = int'($urandom_range(0, DEPTH - 1)); p1d = int'($urandom_range(0, 255));
      end
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0));
    end
    cycle(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
